param_status_array: RTL and testbench

Parametrised per-block status store for the instruction cache: one row per set, each row holding `NUM_BLOCKS` status fields of `BITS_PER_BLOCK` bits (valid, LRU or similar). It sits beside the tag and data arrays. It serves masked writes and one-cycle reads with tag propagation. A built-in sweep FSM clears the whole array after reset and on a flush request, so no external initialisation pass is needed.

---
 rtl/param_status_array_if.sv | 31 +++
 rtl/param_status_array.sv | 148 ++++++++++++++
 tb/tb_param_status_array.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/param_status_array_if.sv
// Request/response bundle for param_status_array: requester drives i_*, the array drives o_*.
interface param_status_array_if #(
    parameter int TAG_WIDTH      = 1,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_BLOCKS     = 8,
    parameter int BITS_PER_BLOCK = 1
);
    localparam int ROW_WIDTH = NUM_BLOCKS * BITS_PER_BLOCK;

    logic                  i_valid;
    logic                  i_wen;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [ROW_WIDTH-1:0]  i_data;
    logic [NUM_BLOCKS-1:0] i_wmask;
    logic [TAG_WIDTH-1:0]  i_tag;
    logic                  i_flush;
    logic                  o_ready;
    logic                  o_valid;
    logic [ROW_WIDTH-1:0]  o_data;
    logic [TAG_WIDTH-1:0]  o_tag;

    modport master (
        output i_valid, i_wen, i_addr, i_data, i_wmask, i_tag, i_flush,
        input  o_ready, o_valid, o_data, o_tag
    );

    modport slave (
        input  i_valid, i_wen, i_addr, i_data, i_wmask, i_tag, i_flush,
        output o_ready, o_valid, o_data, o_tag
    );
endinterface

// File: rtl/param_status_array.sv
// Per-set status store (masked writes, 1-cycle tagged reads) with a self-clearing sweep FSM.
// Optional extra output register stage: define PARAM_STATUS_ARRAY_OUTPUT_REG_EN.
module param_status_array #(
    parameter int TAG_WIDTH      = 1,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_BLOCKS     = 8,
    parameter int BITS_PER_BLOCK = 1
) (
    input  logic                gated_clk,
    input  logic                arst_n,
    param_status_array_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int ROW_WIDTH = NUM_BLOCKS * BITS_PER_BLOCK;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] sweep_addr_r;
    logic [ROW_WIDTH-1:0]  mem_r [DEPTH];

    logic                  ready_s;
    logic                  acc_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  clear_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic [ROW_WIDTH-1:0]  rd_row_s;
    logic [ROW_WIDTH-1:0]  wr_row_s;

    logic                  valid_r;
    logic [ROW_WIDTH-1:0]  data_r;
    logic [TAG_WIDTH-1:0]  tag_r;

    // Request qualification and selection of the row being cleared this cycle.
    always_comb begin
        ready_s  = (state_r == ST_RUN) && !bus.i_flush;
        acc_s    = bus.i_valid && ready_s;
        wr_acc_s = acc_s && bus.i_wen;
        rd_acc_s = acc_s && !bus.i_wen;
        clear_s  = (state_r == ST_SWEEP) || bus.i_flush;
        // The flush cycle itself clears row 0, so a flush costs exactly DEPTH unready cycles.
        if (bus.i_flush) begin
            clr_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
            clr_addr_s = sweep_addr_r;
        end
    end

    // Read-modify-write merge: masked fields take new data, the rest keep the stored value.
    always_comb begin
        rd_row_s = mem_r[bus.i_addr];
        wr_row_s = rd_row_s;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (bus.i_wmask[b]) begin
                wr_row_s[b*BITS_PER_BLOCK +: BITS_PER_BLOCK] = bus.i_data[b*BITS_PER_BLOCK +: BITS_PER_BLOCK];
            end else begin
                wr_row_s[b*BITS_PER_BLOCK +: BITS_PER_BLOCK] = rd_row_s[b*BITS_PER_BLOCK +: BITS_PER_BLOCK];
            end
        end
    end

    assign bus.o_ready = ready_s;

    // Storage array; never reset, the sweep owns initialisation.
    always_ff @(posedge gated_clk) begin
        if (clear_s) begin
            mem_r[clr_addr_s] <= {ROW_WIDTH{1'b0}};
        end else if (wr_acc_s) begin
            mem_r[bus.i_addr] <= wr_row_s;
        end
    end

    // Sweep/run FSM; a flush (in either state) resumes the sweep at row 1 since row 0 is cleared now.
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= ST_SWEEP;
            sweep_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (bus.i_flush) begin
            state_r      <= ST_SWEEP;
            sweep_addr_r <= ADDR_WIDTH'(1'b1);
        end else begin
            case (state_r)
                ST_SWEEP: begin
                    if (sweep_addr_r == {ADDR_WIDTH{1'b1}}) begin
                        state_r      <= ST_RUN;
                        sweep_addr_r <= {ADDR_WIDTH{1'b0}};
                    end else begin
                        state_r      <= ST_SWEEP;
                        sweep_addr_r <= sweep_addr_r + ADDR_WIDTH'(1'b1);
                    end
                end
                ST_RUN: begin
                    state_r      <= ST_RUN;
                    sweep_addr_r <= {ADDR_WIDTH{1'b0}};
                end
                default: begin
                    state_r      <= ST_SWEEP;
                    sweep_addr_r <= {ADDR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // First response stage: data is zero unless a read was accepted.
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_r <= 1'b0;
            data_r  <= {ROW_WIDTH{1'b0}};
            tag_r   <= {TAG_WIDTH{1'b0}};
        end else begin
            valid_r <= rd_acc_s;
            data_r  <= rd_acc_s ? rd_row_s : {ROW_WIDTH{1'b0}};
            tag_r   <= acc_s ? bus.i_tag : {TAG_WIDTH{1'b0}};
        end
    end

`ifdef PARAM_STATUS_ARRAY_OUTPUT_REG_EN
    logic                 valid2_r;
    logic [ROW_WIDTH-1:0] data2_r;
    logic [TAG_WIDTH-1:0] tag2_r;

    // Optional second response stage, re-applying the data mask at the final register.
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            valid2_r <= 1'b0;
            data2_r  <= {ROW_WIDTH{1'b0}};
            tag2_r   <= {TAG_WIDTH{1'b0}};
        end else begin
            valid2_r <= valid_r;
            data2_r  <= valid_r ? data_r : {ROW_WIDTH{1'b0}};
            tag2_r   <= tag_r;
        end
    end

    assign bus.o_valid = valid2_r;
    assign bus.o_data  = data2_r;
    assign bus.o_tag   = tag2_r;
`else
    assign bus.o_valid = valid_r;
    assign bus.o_data  = data_r;
    assign bus.o_tag   = tag_r;
`endif

endmodule

// File: tb/tb_param_status_array.sv
// Self-checking bench for param_status_array: directed plan steps plus random traffic vs a row/countdown model.
module tb_param_status_array;
    localparam int TW    = 1;
    localparam int AW    = 4;
    localparam int NB    = 8;
    localparam int BPB   = 1;
    localparam int RW    = NB * BPB;
    localparam int DEPTH = 2 ** AW;
`ifdef PARAM_STATUS_ARRAY_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic gated_clk = 1'b0;
    logic arst_n    = 1'b0;

    param_status_array_if #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .BITS_PER_BLOCK(BPB)) bus ();

    param_status_array #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .BITS_PER_BLOCK(BPB)) dut (
        .gated_clk (gated_clk),
        .arst_n    (arst_n),
        .bus       (bus.slave)
    );

    always #5 gated_clk = ~gated_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: row contents, remaining not-ready cycles, expected response pipeline.
    logic [RW-1:0] m_mem [DEPTH];
    int            busy;
    logic          pv [LAT];
    logic [RW-1:0] pd [LAT];
    logic [TW-1:0] pt [LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0; pd[i] = '0; pt[i] = '0;
        end
        busy = DEPTH;
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic [RW-1:0] d,
                         input logic [NB-1:0] m, input logic [TW-1:0] t, input logic f);
        bus.i_valid = v;
        bus.i_wen   = w;
        bus.i_addr  = AW'(a);
        bus.i_data  = d;
        bus.i_wmask = m;
        bus.i_tag   = t;
        bus.i_flush = f;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0, '0, 1'b0);
    endtask

    // One clock: check ready, predict, take the edge, then check the registered response.
    task automatic cycle(input string tag);
        logic          exp_ready, acc, nv;
        logic [RW-1:0] nd;
        logic [TW-1:0] nt;
        int            a;
        #1;
        exp_ready = (busy == 0) && !bus.i_flush;
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'(exp_ready));
        acc = bus.i_valid && exp_ready;
        a   = int'(bus.i_addr);
        nv  = acc && !bus.i_wen;
        nd  = nv ? m_mem[a] : '0;
        nt  = acc ? bus.i_tag : '0;
        if (acc && bus.i_wen) begin
            for (int b = 0; b < NB; b++)
                if (bus.i_wmask[b]) m_mem[a][b*BPB +: BPB] = bus.i_data[b*BPB +: BPB];
        end
        if (bus.i_flush) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            busy = DEPTH - 1;
        end else if (busy > 0) begin
            busy--;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1]; pd[i] = pd[i-1]; pt[i] = pt[i-1];
        end
        pv[0] = nv; pd[0] = nd; pt[0] = nt;
        @(posedge gated_clk);
        #1;
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'(pv[LAT-1]));
        chk({tag, "_data"},  32'(bus.o_data),  32'(pd[LAT-1]));
        chk({tag, "_tag"},   32'(bus.o_tag),   32'(pt[LAT-1]));
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data",  32'(bus.o_data),  32'd0);
        chk("rst_tag",   32'(bus.o_tag),   32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        @(posedge gated_clk); #1;
        arst_n = 1'b1;

        // Reset/sweep: a held read at row 3 is accepted on the first ready cycle and returns zero.
        drive(1'b1, 1'b0, 3, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cycle("sweep");
        idle();
        for (int i = 0; i < LAT; i++) cycle("sweep_rsp");

        // Masked write/read on row 5, expecting 0x0E.
        drive(1'b1, 1'b1, 5, 8'hFF, 8'h0F, 1'b0, 1'b0); cycle("mw1");
        drive(1'b1, 1'b1, 5, 8'h00, 8'h01, 1'b1, 1'b0); cycle("mw2");
        drive(1'b1, 1'b0, 5, 8'h00, 8'h00, 1'b1, 1'b0); cycle("mrd");
        idle();
        for (int i = 1; i < LAT; i++) cycle("mrd_lat");
        chk("mask_result", 32'(bus.o_data), 32'h0E);
        cycle("mrd_end");

        // Back-to-back write then read of row 2.
        drive(1'b1, 1'b1, 2, 8'hA5, 8'hFF, 1'b0, 1'b0); cycle("b2b_wr");
        drive(1'b1, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0); cycle("b2b_rd");
        idle();
        for (int i = 1; i < LAT; i++) cycle("b2b_lat");
        chk("b2b_result", 32'(bus.o_data), 32'hA5);
        cycle("b2b_end");

        // No-op write (mask 0) must leave row 2 untouched.
        drive(1'b1, 1'b1, 2, 8'h3C, 8'h00, 1'b1, 1'b0); cycle("nop_wr");

        // Flush collides with a read of row 2; afterwards row 2 reads zero.
        drive(1'b1, 1'b0, 2, 8'h00, 8'h00, 1'b1, 1'b1); cycle("fl_col");
        idle();
        for (int i = 0; i < DEPTH; i++) cycle("fl_sweep");
        drive(1'b1, 1'b0, 2, 8'h00, 8'h00, 1'b1, 1'b0); cycle("fl_rd");
        idle();
        for (int i = 0; i < LAT; i++) cycle("fl_rsp");

        // Flush mid-sweep at row 9 restarts the sweep.
        drive(1'b0, 1'b0, 0, '0, '0, '0, 1'b1); cycle("ms_f1");
        idle();
        for (int i = 0; i < 8; i++) cycle("ms_run");
        drive(1'b0, 1'b0, 0, '0, '0, '0, 1'b1); cycle("ms_f2");
        idle();
        for (int i = 0; i < DEPTH; i++) cycle("ms_sweep");

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  RW'($urandom), NB'($urandom), TW'($urandom), 1'($urandom_range(0, 49) == 0));
            cycle("rnd");
        end
        idle();
        for (int i = 0; i < DEPTH; i++) cycle("rnd_drain");

        // Reset while a read response is showing: outputs clear asynchronously.
        drive(1'b1, 1'b0, 7, '0, '0, 1'b1, 1'b0); cycle("rr_rd");
        idle();
        for (int i = 1; i < LAT; i++) cycle("rr_lat");
        chk("rr_pre_valid", 32'(bus.o_valid), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rr_valid", 32'(bus.o_valid), 32'd0);
        chk("rr_data",  32'(bus.o_data),  32'd0);
        chk("rr_tag",   32'(bus.o_tag),   32'd0);
        chk("rr_ready", 32'(bus.o_ready), 32'd0);
        model_reset();
        @(posedge gated_clk); #1;
        arst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle("rr_sweep");
        drive(1'b1, 1'b0, 7, '0, '0, 1'b0, 1'b0); cycle("rr_after");
        idle();
        for (int i = 0; i < LAT; i++) cycle("rr_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
